control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired Mini SRC control unit that generates, each clock, the datapath control strobes a bench otherwise drives by hand.
- Steps through the T-state fetch sequence: T0–T2.
- Then decodes the opcode in the IR and runs the execute steps (T3 onward) for the supported instruction classes.
- Sits beside cpu_phase2 and drives its control inputs: the generator of the strobe protocol the datapath consumes.

Parameters:
- OPW, 5, opcode width: IR[31:27]; also the width of operation.
- IRW, 32, instruction register width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- ir  in  32  datapath IR contents; valid from T3 onward.
- stop  in  1  pause request, sampled only at instruction boundaries.
- PCout, ZHighOut, ZLowOut, MDRout, HIout, LOout  out  1 each  bus source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load enables.
- IncPC, MDRread  out  1 each  PC-increment mode, memory-read select for the MDR.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  select-and-encode controls.
- operation  out  5  ALU op code, same encoding as the opcode.
- run  out  1  high while the machine is sequencing.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (ports clk, clr).
- While clr=0: state=T0, every output 0 including operation and run.
- After release: first rising edge begins T0; run=1.
- States: T0, T1, T2, T3, T4, T5, T6, PAUSE, HALT, held in a 4-bit register.
- Outputs are Moore: decoded from state plus op=ir[31:27]. Any strobe not listed for a step is 0; operation=0 unless listed.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLowOut, PCin, MDRread, MDRin.
  - T2: MDRout, IRin.
- Execute (opcodes in package):
  - R-type ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, operation=op, Zin.
    - T5: ZLowOut, Gra, Rin.
  - ADDI, ANDI, ORI:
    - T3: Grb, Rout, Yin.
    - T4: Cout, operation=op, Zin.
    - T5: ZLowOut, Gra, Rin.
  - LDI:
    - T3: Grb, BAout, Yin.
    - T4: Cout, operation=OP_ADD, Zin.
    - T5: ZLowOut, Gra, Rin.
  - NEG, NOT:
    - T3: Grb, Rout, operation=op, Zin.
    - T4: ZLowOut, Gra, Rin.
  - MUL, DIV:
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, operation=op, Zin.
    - T5: ZLowOut, LOin.
    - T6: ZHighOut, HIin.
  - MFHI: T3: Gra, Rin, HIout.
  - MFLO: T3: Gra, Rin, LOout.
  - NOP and any unlisted opcode: T3 asserts nothing.
  - HALT: T3 asserts nothing; next state HALT.
- Last step of each class is its boundary:
  - stop=1 there -> PAUSE; otherwise -> T0.
  - Instruction lengths: MFHI/MFLO/NOP 4 cycles, NEG/NOT 5, ALU/imm/LDI 6, MUL/DIV 7.
- PAUSE: all strobes 0, run=0. Leaves to T0 on the first edge with stop=0.
- HALT: all strobes 0, run=0. Leaves only through clr.
- stop asserted mid-instruction has no effect until the boundary.
- clr asserted mid-instruction aborts immediately: outputs 0 asynchronously, restart at T0.
- ir changes during T3–T6 are the datapath's fault; the opcode is not latched internally.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - State encodings: T0=0 … T6=6, PAUSE=7, HALT=8.
  - Opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, ADDI 01100, ANDI 01101, ORI 01110, MUL 01111, DIV 10000, NEG 10001, NOT 10010, LDI 00001, MFHI 11000, MFLO 11001, NOP 11010, HALT 11011.
  - An instruction-class enum.
- One sub-module, ctrl_decode: combinational op -> class plus last-step index. Sequencer and output decode stay in control_sequencer.

Test Plan:
- clr low then release, ir=MFLO R3 (0xC9800000), stop=0 -> T0 {PCout, MARin, IncPC, Zin}, T1 {ZLowOut, PCin, MDRread, MDRin}, T2 {MDRout, IRin}, T3 {Gra, Rin, LOout}, then T0 again.
- ir=ADD (op 00011) -> T4 operation=5'b00011 with Grc, Rout, Zin; T5 ZLowOut, Gra, Rin; 6 cycles per instruction.
- ir=MUL (op 01111) -> T5 {ZLowOut, LOin}, T6 {ZHighOut, HIin}; next state T0 after 7 cycles.
- ir=ADDI, stop raised during T4 -> completes T5, enters PAUSE with run=0; stop dropped -> T0 next edge, run=1.
- ir=HALT (op 11011) -> T3, then HALT with run=0 and all outputs 0 for 20 cycles despite stop toggling; clr pulse -> T0.
- clr pulled low mid-T4 of DIV, between edges -> outputs 0 immediately, no HIin/LOin ever asserted; restart at T0 after release.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the Mini SRC hardwired control unit:
// state encodings, opcodes, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

  localparam int OPW = 5;
  localparam int IRW = 32;

  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_PAUSE = 4'd7,
    S_HALT  = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU,
    CL_IMM,
    CL_LDI,
    CL_UNARY,
    CL_MULDIV,
    CL_MFHI,
    CL_MFLO,
    CL_HALT
  } iclass_t;

  typedef struct packed {
    logic           pc_out;
    logic           zhigh_out;
    logic           zlow_out;
    logic           mdr_out;
    logic           hi_out;
    logic           lo_out;
    logic           mar_in;
    logic           z_in;
    logic           pc_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           hi_in;
    logic           lo_in;
    logic           inc_pc;
    logic           mdr_read;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           r_in;
    logic           r_out;
    logic           ba_out;
    logic           c_out;
    logic [OPW-1:0] operation;
    logic           run;
  } ctrl_t;

  function automatic logic [OPW-1:0] get_op(
    input logic [IRW-1:0] ir
  );
    return ir[IRW-1 -: OPW];
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath:
// IR and stop flow in, strobes flow out.
interface control_sequencer_if #(
  parameter int IRW = 32,
  parameter int OPW = 5
);
  logic [IRW-1:0] ir;
  logic           stop;
  logic           PCout;
  logic           ZHighOut;
  logic           ZLowOut;
  logic           MDRout;
  logic           HIout;
  logic           LOout;
  logic           MARin;
  logic           Zin;
  logic           PCin;
  logic           MDRin;
  logic           IRin;
  logic           Yin;
  logic           HIin;
  logic           LOin;
  logic           IncPC;
  logic           MDRread;
  logic           Gra;
  logic           Grb;
  logic           Grc;
  logic           Rin;
  logic           Rout;
  logic           BAout;
  logic           Cout;
  logic [OPW-1:0] operation;
  logic           run;

  modport master (
    input  ir, stop,
    output PCout, ZHighOut, ZLowOut, MDRout,
    output HIout, LOout,
    output MARin, Zin, PCin, MDRin, IRin,
    output Yin, HIin, LOin,
    output IncPC, MDRread,
    output Gra, Grb, Grc, Rin, Rout,
    output BAout, Cout,
    output operation, run
  );

  modport slave (
    output ir, stop,
    input  PCout, ZHighOut, ZLowOut, MDRout,
    input  HIout, LOout,
    input  MARin, Zin, PCin, MDRin, IRin,
    input  Yin, HIin, LOin,
    input  IncPC, MDRread,
    input  Gra, Grb, Grc, Rin, Rout,
    input  BAout, Cout,
    input  operation, run
  );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode to instruction class, plus the T-step index that
// ends the instruction (its boundary).
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  output iclass_t        o_cls,
  output logic [2:0]     o_last
);

  iclass_t w_cls;

  always_comb begin
    w_cls = CL_NOP;
    unique case (i_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL:         w_cls = CL_ALU;
      OP_ADDI, OP_ANDI,
      OP_ORI:                 w_cls = CL_IMM;
      OP_LDI:                 w_cls = CL_LDI;
      OP_NEG, OP_NOT:         w_cls = CL_UNARY;
      OP_MUL, OP_DIV:         w_cls = CL_MULDIV;
      OP_MFHI:                w_cls = CL_MFHI;
      OP_MFLO:                w_cls = CL_MFLO;
      OP_HALT:                w_cls = CL_HALT;
      default:                w_cls = CL_NOP;
    endcase
  end

  always_comb begin
    o_last = 3'd3;
    unique case (1'b1)
      (w_cls == CL_MULDIV): o_last = 3'd6;
      (w_cls == CL_ALU),
      (w_cls == CL_IMM),
      (w_cls == CL_LDI):    o_last = 3'd5;
      (w_cls == CL_UNARY):  o_last = 3'd4;
      default:              o_last = 3'd3;
    endcase
  end

  assign o_cls = w_cls;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0-T2, then
// class-specific execute steps, with pause and halt handling.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = cpu_ctrl_pkg::OPW,
  parameter int IRW = cpu_ctrl_pkg::IRW
)(
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  state_t          r_state;
  state_t          w_next;
  logic            r_go;
  iclass_t         w_cls;
  logic [2:0]      w_last;
  logic [OPW-1:0]  w_op;
  logic            w_bound;
  ctrl_t           w_ctl;
  logic            w_unused_ir;

  assign w_op        = bus.ir[IRW-1 -: OPW];
  assign w_unused_ir = ^bus.ir;

  ctrl_decode u_dec (
    .i_op   (w_op),
    .o_cls  (w_cls),
    .o_last (w_last)
  );

  // r_go holds the machine idle in T0 until the first edge after clr lifts
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_T0;
      r_go    <= 1'b0;
    end else begin
      r_go <= 1'b1;
      if (r_go) r_state <= w_next;
    end
  end

  assign w_bound = (r_state >= {1'b0, w_last});

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_T0: w_next = S_T1;
      S_T1: w_next = S_T2;
      S_T2: w_next = S_T3;
      S_T3, S_T4, S_T5, S_T6: begin
        if (!w_bound) begin
          w_next = state_t'(r_state + 4'd1);
        end else if (w_cls == CL_HALT) begin
          w_next = S_HALT;
        end else if (bus.stop) begin
          w_next = S_PAUSE;
        end else begin
          w_next = S_T0;
        end
      end
      S_PAUSE: begin
        if (!bus.stop) w_next = S_T0;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_T0;
    endcase
  end

  always_comb begin
    w_ctl = '0;
    if (r_go) begin
      unique case (r_state)
        S_T0: begin
          w_ctl.run    = 1'b1;
          w_ctl.pc_out = 1'b1;
          w_ctl.mar_in = 1'b1;
          w_ctl.inc_pc = 1'b1;
          w_ctl.z_in   = 1'b1;
        end
        S_T1: begin
          w_ctl.run      = 1'b1;
          w_ctl.zlow_out = 1'b1;
          w_ctl.pc_in    = 1'b1;
          w_ctl.mdr_read = 1'b1;
          w_ctl.mdr_in   = 1'b1;
        end
        S_T2: begin
          w_ctl.run     = 1'b1;
          w_ctl.mdr_out = 1'b1;
          w_ctl.ir_in   = 1'b1;
        end
        S_T3: begin
          w_ctl.run = 1'b1;
          unique case (w_cls)
            CL_ALU, CL_IMM: begin
              w_ctl.grb   = 1'b1;
              w_ctl.r_out = 1'b1;
              w_ctl.y_in  = 1'b1;
            end
            CL_LDI: begin
              w_ctl.grb    = 1'b1;
              w_ctl.ba_out = 1'b1;
              w_ctl.y_in   = 1'b1;
            end
            CL_UNARY: begin
              w_ctl.grb       = 1'b1;
              w_ctl.r_out     = 1'b1;
              w_ctl.operation = w_op;
              w_ctl.z_in      = 1'b1;
            end
            CL_MULDIV: begin
              w_ctl.gra   = 1'b1;
              w_ctl.r_out = 1'b1;
              w_ctl.y_in  = 1'b1;
            end
            CL_MFHI: begin
              w_ctl.gra    = 1'b1;
              w_ctl.r_in   = 1'b1;
              w_ctl.hi_out = 1'b1;
            end
            CL_MFLO: begin
              w_ctl.gra    = 1'b1;
              w_ctl.r_in   = 1'b1;
              w_ctl.lo_out = 1'b1;
            end
            default: ;
          endcase
        end
        S_T4: begin
          w_ctl.run = 1'b1;
          unique case (w_cls)
            CL_ALU: begin
              w_ctl.grc       = 1'b1;
              w_ctl.r_out     = 1'b1;
              w_ctl.operation = w_op;
              w_ctl.z_in      = 1'b1;
            end
            CL_IMM: begin
              w_ctl.c_out     = 1'b1;
              w_ctl.operation = w_op;
              w_ctl.z_in      = 1'b1;
            end
            CL_LDI: begin
              w_ctl.c_out     = 1'b1;
              w_ctl.operation = OP_ADD;
              w_ctl.z_in      = 1'b1;
            end
            CL_UNARY: begin
              w_ctl.zlow_out = 1'b1;
              w_ctl.gra      = 1'b1;
              w_ctl.r_in     = 1'b1;
            end
            CL_MULDIV: begin
              w_ctl.grb       = 1'b1;
              w_ctl.r_out     = 1'b1;
              w_ctl.operation = w_op;
              w_ctl.z_in      = 1'b1;
            end
            default: ;
          endcase
        end
        S_T5: begin
          w_ctl.run = 1'b1;
          unique case (w_cls)
            CL_ALU, CL_IMM, CL_LDI: begin
              w_ctl.zlow_out = 1'b1;
              w_ctl.gra      = 1'b1;
              w_ctl.r_in     = 1'b1;
            end
            CL_MULDIV: begin
              w_ctl.zlow_out = 1'b1;
              w_ctl.lo_in    = 1'b1;
            end
            default: ;
          endcase
        end
        S_T6: begin
          w_ctl.run = 1'b1;
          if (w_cls == CL_MULDIV) begin
            w_ctl.zhigh_out = 1'b1;
            w_ctl.hi_in     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PCout     = w_ctl.pc_out;
  assign bus.ZHighOut  = w_ctl.zhigh_out;
  assign bus.ZLowOut   = w_ctl.zlow_out;
  assign bus.MDRout    = w_ctl.mdr_out;
  assign bus.HIout     = w_ctl.hi_out;
  assign bus.LOout     = w_ctl.lo_out;
  assign bus.MARin     = w_ctl.mar_in;
  assign bus.Zin       = w_ctl.z_in;
  assign bus.PCin      = w_ctl.pc_in;
  assign bus.MDRin     = w_ctl.mdr_in;
  assign bus.IRin      = w_ctl.ir_in;
  assign bus.Yin       = w_ctl.y_in;
  assign bus.HIin      = w_ctl.hi_in;
  assign bus.LOin      = w_ctl.lo_in;
  assign bus.IncPC     = w_ctl.inc_pc;
  assign bus.MDRread   = w_ctl.mdr_read;
  assign bus.Gra       = w_ctl.gra;
  assign bus.Grb       = w_ctl.grb;
  assign bus.Grc       = w_ctl.grc;
  assign bus.Rin       = w_ctl.r_in;
  assign bus.Rout      = w_ctl.r_out;
  assign bus.BAout     = w_ctl.ba_out;
  assign bus.Cout      = w_ctl.c_out;
  assign bus.operation = w_ctl.operation;
  assign bus.run       = w_ctl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction table plus
// pause, halt and mid-instruction reset sequences.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if u_if ();

  control_sequencer u_dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if)
  );

  localparam logic [28:0] B_PCOUT  = 29'h1 << 28;
  localparam logic [28:0] B_ZHI    = 29'h1 << 27;
  localparam logic [28:0] B_ZLO    = 29'h1 << 26;
  localparam logic [28:0] B_MDROUT = 29'h1 << 25;
  localparam logic [28:0] B_HIOUT  = 29'h1 << 24;
  localparam logic [28:0] B_LOOUT  = 29'h1 << 23;
  localparam logic [28:0] B_MARIN  = 29'h1 << 22;
  localparam logic [28:0] B_ZIN    = 29'h1 << 21;
  localparam logic [28:0] B_PCIN   = 29'h1 << 20;
  localparam logic [28:0] B_MDRIN  = 29'h1 << 19;
  localparam logic [28:0] B_IRIN   = 29'h1 << 18;
  localparam logic [28:0] B_YIN    = 29'h1 << 17;
  localparam logic [28:0] B_HIIN   = 29'h1 << 16;
  localparam logic [28:0] B_LOIN   = 29'h1 << 15;
  localparam logic [28:0] B_INCPC  = 29'h1 << 14;
  localparam logic [28:0] B_MDRRD  = 29'h1 << 13;
  localparam logic [28:0] B_GRA    = 29'h1 << 12;
  localparam logic [28:0] B_GRB    = 29'h1 << 11;
  localparam logic [28:0] B_GRC    = 29'h1 << 10;
  localparam logic [28:0] B_RIN    = 29'h1 << 9;
  localparam logic [28:0] B_ROUT   = 29'h1 << 8;
  localparam logic [28:0] B_BAOUT  = 29'h1 << 7;
  localparam logic [28:0] B_COUT   = 29'h1 << 6;
  localparam logic [28:0] B_RUN    = 29'h1;

  localparam logic [28:0] F0 =
    B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [28:0] F1 =
    B_ZLO | B_PCIN | B_MDRRD | B_MDRIN | B_RUN;
  localparam logic [28:0] F2 = B_MDROUT | B_IRIN | B_RUN;

  localparam logic [28:0] E_BRY = B_GRB | B_ROUT | B_YIN | B_RUN;
  localparam logic [28:0] E_WB  = B_ZLO | B_GRA | B_RIN | B_RUN;

  wire [28:0] w_act = {
    u_if.PCout, u_if.ZHighOut, u_if.ZLowOut, u_if.MDRout,
    u_if.HIout, u_if.LOout, u_if.MARin, u_if.Zin,
    u_if.PCin, u_if.MDRin, u_if.IRin, u_if.Yin,
    u_if.HIin, u_if.LOin, u_if.IncPC, u_if.MDRread,
    u_if.Gra, u_if.Grb, u_if.Grc, u_if.Rin,
    u_if.Rout, u_if.BAout, u_if.Cout,
    u_if.operation, u_if.run
  };

  typedef struct {
    string              nm;
    logic [31:0]        ir;
    int                 len;
    logic [3:0][28:0]   ex;
  } vec_t;

  vec_t        tbl[$];
  logic [28:0] sb[$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [28:0] opv(input logic [4:0] op);
    return {23'b0, op, 1'b0};
  endfunction

  task automatic check(input string nm,
                       input logic [28:0] act,
                       input logic [28:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic [31:0] ir,
                         input int len,
                         input logic [28:0] e3, input logic [28:0] e4,
                         input logic [28:0] e5, input logic [28:0] e6);
    vec_t v;
    v.nm = nm;
    v.ir = ir;
    v.len = len;
    v.ex[0] = e3;
    v.ex[1] = e4;
    v.ex[2] = e5;
    v.ex[3] = e6;
    tbl.push_back(v);
  endtask

  // expectations go on the scoreboard, then one pop per negedge
  task automatic run_instr(input vec_t v, input int stop_k,
                           input int n);
    logic [28:0] e;
    sb.push_back(F0);
    sb.push_back(F1);
    sb.push_back(F2);
    for (int k = 3; k < v.len; k++) sb.push_back(v.ex[k-3]);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s_T%0d", v.nm, k), w_act, e);
      if (k == 0) u_if.ir = v.ir;
      if (k == stop_k) u_if.stop = 1'b1;
    end
    sb.delete();
  endtask

  initial begin
    vec_t vaddi, vdiv, vmul, vhalt, vmflo;
    u_if.ir   = 32'hC980_0000;
    u_if.stop = 1'b0;

    add_vec("MFLO", 32'hC980_0000, 4,
            B_GRA | B_RIN | B_LOOUT | B_RUN, 0, 0, 0);
    add_vec("ADD", 32'h1811_2345, 6, E_BRY,
            B_GRC | B_ROUT | B_ZIN | opv(5'b00011) | B_RUN, E_WB, 0);
    add_vec("SUB", 32'h2000_0010, 6, E_BRY,
            B_GRC | B_ROUT | B_ZIN | opv(5'b00100) | B_RUN, E_WB, 0);
    add_vec("ROL", 32'h5800_0000, 6, E_BRY,
            B_GRC | B_ROUT | B_ZIN | opv(5'b01011) | B_RUN, E_WB, 0);
    add_vec("ADDI", 32'h6000_0007, 6, E_BRY,
            B_COUT | B_ZIN | opv(5'b01100) | B_RUN, E_WB, 0);
    add_vec("ORI", 32'h7000_00FF, 6, E_BRY,
            B_COUT | B_ZIN | opv(5'b01110) | B_RUN, E_WB, 0);
    add_vec("LDI", 32'h0800_0042, 6,
            B_GRB | B_BAOUT | B_YIN | B_RUN,
            B_COUT | B_ZIN | opv(5'b00011) | B_RUN, E_WB, 0);
    add_vec("NEG", 32'h8800_0000, 5,
            B_GRB | B_ROUT | B_ZIN | opv(5'b10001) | B_RUN,
            E_WB, 0, 0);
    add_vec("NOT", 32'h9000_0000, 5,
            B_GRB | B_ROUT | B_ZIN | opv(5'b10010) | B_RUN,
            E_WB, 0, 0);
    add_vec("MUL", 32'h7800_0000, 7,
            B_GRA | B_ROUT | B_YIN | B_RUN,
            B_GRB | B_ROUT | B_ZIN | opv(5'b01111) | B_RUN,
            B_ZLO | B_LOIN | B_RUN, B_ZHI | B_HIIN | B_RUN);
    add_vec("DIV", 32'h8000_0000, 7,
            B_GRA | B_ROUT | B_YIN | B_RUN,
            B_GRB | B_ROUT | B_ZIN | opv(5'b10000) | B_RUN,
            B_ZLO | B_LOIN | B_RUN, B_ZHI | B_HIIN | B_RUN);
    add_vec("MFHI", 32'hC000_0000, 4,
            B_GRA | B_RIN | B_HIOUT | B_RUN, 0, 0, 0);
    add_vec("NOP", 32'hD000_0000, 4, B_RUN, 0, 0, 0);
    add_vec("OP00", 32'h0123_4567, 4, B_RUN, 0, 0, 0);
    add_vec("OP1F", 32'hF800_0000, 4, B_RUN, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("reset", w_act, 29'h0);
    clr = 1'b1;

    foreach (tbl[i]) run_instr(tbl[i], -1, tbl[i].len);

    vaddi = tbl[4];
    vmul  = tbl[9];
    vdiv  = tbl[10];
    vmflo = tbl[0];
    vhalt = tbl[0];
    vhalt.nm = "HALT";
    vhalt.ir = 32'hD800_0000;
    vhalt.ex[0] = B_RUN;

    vaddi.nm = "ADDIstop";
    run_instr(vaddi, 4, vaddi.len);
    @(negedge clk);
    check("pause0", w_act, 29'h0);
    @(negedge clk);
    check("pause1", w_act, 29'h0);
    u_if.stop = 1'b0;

    vdiv.nm = "DIVabort";
    run_instr(vdiv, -1, 5);
    #2 clr = 1'b0;
    #1 check("abort_now", w_act, 29'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold%0d", i), w_act, 29'h0);
    end
    clr = 1'b1;
    vmul.nm = "MULrestart";
    run_instr(vmul, -1, vmul.len);

    run_instr(vhalt, -1, vhalt.len);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt%0d", i), w_act, 29'h0);
      u_if.stop = i[0];
    end
    u_if.stop = 1'b0;
    u_if.ir = 32'hC980_0000;
    #2 clr = 1'b0;
    #1 check("halt_clr", w_act, 29'h0);
    @(negedge clk);
    clr = 1'b1;
    vmflo.nm = "MFLOpost";
    run_instr(vmflo, -1, vmflo.len);
    @(negedge clk);
    check("post_T0", w_act, F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
